// File: rtl/polar_pkg.sv
// Shared types and elaboration helpers for the polar encoder.
package polar_pkg;

  localparam int unsigned LOG_N_MAX = 10;
  localparam int unsigned N_MAX = 1 << LOG_N_MAX;

  typedef enum logic [1:0] {LOAD, ENCODE, OUTPUT} enc_state_t;

  function automatic int unsigned popcount(input logic [N_MAX-1:0] v);
    int unsigned c;
    c = 0;
    for (int unsigned i = 0; i < N_MAX; i++) begin
      c += 32'(v[i]);
    end
    return c;
  endfunction

  // Never returns 0, so it can size a counter directly.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) begin
      r++;
    end
    return (r == 0) ? 32'd1 : r;
  endfunction

endpackage

// File: rtl/polar_butterfly_stage.sv
// One stage of the natural-order polar transform: x[i] ^= x[i + 2**s] wherever bit s of i is 0.
module polar_butterfly_stage
  import polar_pkg::*;
#(
  parameter int unsigned LOG_N = 3,
  parameter int unsigned SW    = clog2(LOG_N + 1)
) (
  input  logic [(2**LOG_N)-1:0] x_in,
  input  logic [SW-1:0]         s,
  output logic [(2**LOG_N)-1:0] x_out
);

  localparam int unsigned N = 2 ** LOG_N;

  logic [N-1:0] partner;
  logic [N-1:0] head;

  always_comb begin
    partner = x_in >> (32'd1 << s);
    for (int unsigned i = 0; i < N; i++) begin
      head[i] = ((i >> s) & 32'd1) == 32'd0;
    end
    x_out = x_in ^ (partner & head);
  end

endmodule

// File: rtl/polar_encoder.sv
// Serial polar encoder: loads info bits around frozen zeros, runs LOG_N butterfly stages,
// then streams the codeword out with a valid/ready handshake.
module polar_encoder
  import polar_pkg::*;
#(
  parameter int unsigned           LOG_N       = 3,
  parameter logic [(2**LOG_N)-1:0] FROZEN_MASK = 8'h17
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_bit,
  output logic out_valid,
  input  logic out_ready,
  output logic out_bit,
  output logic out_last,
  output logic busy
);

  localparam int unsigned     N           = 2 ** LOG_N;
  localparam int unsigned     SW          = clog2(LOG_N + 1);
  localparam logic [LOG_N:0]  LastIdx     = (LOG_N + 1)'(N - 1);
  localparam logic [SW-1:0]   LastStage   = SW'(LOG_N - 1);
  localparam int unsigned     FrozenCount = popcount(N_MAX'(FROZEN_MASK));

  if (LOG_N < 1 || LOG_N > LOG_N_MAX) begin : g_bad_log_n
    $error("polar_encoder: LOG_N must be in 1..%0d", LOG_N_MAX);
  end
  if (FrozenCount >= N) begin : g_bad_mask
    $error("polar_encoder: FROZEN_MASK leaves no information positions");
  end

  enc_state_t     state_q, state_d;
  logic [LOG_N:0] pos_q, pos_d;
  logic [LOG_N:0] idx_q, idx_d;
  logic [SW-1:0]  stage_q, stage_d;
  logic [N-1:0]   x_q, x_d;
  logic [N-1:0]   x_bfly;
  logic           frozen;

  assign frozen = FROZEN_MASK[pos_q[LOG_N-1:0]];

  polar_butterfly_stage #(
    .LOG_N (LOG_N),
    .SW    (SW)
  ) u_bfly (
    .x_in  (x_q),
    .s     (stage_q),
    .x_out (x_bfly)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      pos_q   <= '0;
      idx_q   <= '0;
      stage_q <= '0;
      x_q     <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      x_q     <= x_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    idx_d   = idx_q;
    stage_d = stage_q;
    x_d     = x_q;
    unique case (state_q)
      LOAD: begin
        // Frozen slots advance on their own; info slots wait for in_valid.
        if (frozen || in_valid) begin
          x_d[pos_q[LOG_N-1:0]] = frozen ? 1'b0 : in_bit;
          if (pos_q == LastIdx) begin
            state_d = ENCODE;
            stage_d = '0;
          end else begin
            pos_d = pos_q + 1'b1;
          end
        end
      end
      ENCODE: begin
        x_d = x_bfly;
        if (stage_q == LastStage) begin
          state_d = OUTPUT;
          idx_d   = '0;
        end else begin
          stage_d = stage_q + 1'b1;
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          if (idx_q == LastIdx) begin
            state_d = LOAD;
            pos_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_bit   = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      LOAD:   in_ready = ~frozen;
      ENCODE: busy = 1'b1;
      OUTPUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_bit   = x_q[idx_q[LOG_N-1:0]];
        out_last  = (idx_q == LastIdx);
      end
      default: ;
    endcase
  end

endmodule

// File: doc/polar_encoder.md
Name: polar_encoder

Overview:
- Sequential polar-code encoder; the transmit-side counterpart of the SC decoder's LLR f/g datapath.
- Accepts K serial info bits and inserts zeros at frozen positions to build u[0..N-1].
- Computes x = u·F^{⊗n} (F = [[1,0],[1,1]], natural order, no bit-reversal) using one butterfly stage per clock.
- Streams x[0..N-1] out serially with valid/ready; feeds the modulator/channel model in the rateless polar test chain.

Parameters:
- LOG_N, 3, log2 of code length; N = 2**LOG_N, legal range 1..10.
- FROZEN_MASK, 8'h17, N-bit vector; bit i = 1 means u[i] is frozen to 0. K = N − popcount(FROZEN_MASK), K ≥ 1.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  info bit available.
- in_ready  out  1  encoder accepts in_bit this cycle.
- in_bit  in  1  info bit; consumed in ascending info-index order.
- out_valid  out  1  coded bit valid.
- out_ready  in  1  downstream accepts out_bit.
- out_bit  out  1  coded bit x[idx], idx ascending from 0.
- out_last  out  1  high with out_valid when idx = N−1.
- busy  out  1  high in ENCODE and OUTPUT.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state ← LOAD; pos ← 0; stage ← 0; idx ← 0; x register ← all zeros.
  - Outputs after reset: in_ready per LOAD rules (0 if FROZEN_MASK[0]); out_valid=0; out_last=0; out_bit=0; busy=0.
  - Reset mid-frame discards the partial frame; no output for that frame.
- State LOAD:
  - pos counts 0..N−1.
  - If FROZEN_MASK[pos]=1: in_ready=0, x[pos] ← 0, pos increments unconditionally (one cycle per frozen position).
  - If FROZEN_MASK[pos]=0: in_ready=1. When in_valid=1, x[pos] ← in_bit and pos increments. Otherwise hold.
  - When position N−1 is written, go to ENCODE with stage ← 0.
- State ENCODE:
  - Exactly LOG_N cycles, one per stage s = 0..LOG_N−1.
  - For every i with bit s of i clear: x[i] ← x[i] ^ x[i + 2**s]. All other x[i] are unchanged.
  - After stage LOG_N−1, go to OUTPUT with idx ← 0.
  - in_ready=0 and out_valid=0 throughout.
- State OUTPUT:
  - out_valid=1; out_bit = x[idx]; out_last = (idx == N−1).
  - idx increments only on out_valid & out_ready. out_bit, out_valid and out_last are held stable while out_ready=0.
  - The handshake with out_last=1 returns to LOAD with pos ← 0 on the next cycle. in_ready is never high in the same cycle as out_valid.
- Latency: the last LOAD write cycle, then LOG_N ENCODE cycles. out_valid rises on cycle LOG_N+1 after the last write.
- Throughput: one frame per (N + LOG_N + N) cycles minimum, given in_valid=1 and out_ready=1 continuously.
- Counters: pos and idx are LOG_N+1 bits wide, so no overflow at N−1. stage is clog2(LOG_N+1) bits. All arithmetic is GF(2) XOR; no carries.
- in_valid while in_ready=0 is ignored; the bit is not consumed.
- FROZEN_MASK all-ones is illegal. It is rejected by an elaboration-time assertion.

Decomposition:
- polar_pkg holds:
  - state enum typedef enc_state_t {LOAD, ENCODE, OUTPUT}
  - function popcount for K
  - function clog2
  - shared LOG_N_MAX constant
- One sub-module: polar_butterfly_stage. It is purely combinational, with inputs x_in[N], stage index s and output x_out[N], implementing the single-stage XOR rule. The top registers its output during ENCODE.

Test Plan:
- N=8, mask 8'h17, info bits 1,1,1,1 (u=[0,0,0,1,0,1,1,1]) with out_ready=1 -> out_bit sequence x[0..7] = 0,1,1,0,1,0,0,1; out_last on 8th bit; out_valid first high 4 cycles after the last write.
- N=8, mask 8'h17, info bits 0,0,0,1 (only u7=1) -> x = 1,1,1,1,1,1,1,1.
- Backpressure: same stimulus as test 1, with out_ready toggled 1,0,0,1 repeating -> identical bit sequence; out_bit/out_last stable during stalls; exactly 8 handshakes.
- Input gaps and frozen skipping: in_valid low for 3 cycles before each info bit -> in_ready=0 at pos 0,1,2,4; no bit consumed while in_ready=0; output matches test 1.
- rst asserted after 2 info bits, then a full frame of 0,0,0,1 -> no output from the aborted frame; output all ones; busy=0 on the cycle after reset.
- Back-to-back frames (1,1,1,1 then 0,0,0,1) with in_valid held high -> in_ready is 0 during ENCODE/OUTPUT; second frame accepted starting the cycle after the first frame's out_last handshake; both outputs correct.
